muldiv_seq: RTL

Multi-cycle sequencer for the MUL, DIV and MOD operations, which the single-cycle ALU otherwise computes combinationally and which sets the critical path. The execute stage sends these three opcodes here instead of to the ALU. It stalls on `busy` and takes the result on `done`. Results are bit-identical to the ALU's definitions, so software sees no difference.

---
 rtl/muldiv_seq_pkg.sv | 34 +++
 rtl/muldiv_step.sv | 38 +++
 rtl/muldiv_seq.sv | 109 ++++++++++
 3 files changed

// File: rtl/muldiv_seq_pkg.sv
// Shared decode header: ALU opcodes and muldiv sequencer states.
// Imported by the execute-stage muldiv unit.
package muldiv_seq_pkg;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_AND  = 4'h2;
  localparam logic [3:0] ALU_OR   = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4;
  localparam logic [3:0] ALU_SLL  = 4'h5;
  localparam logic [3:0] ALU_SRL  = 4'h6;
  localparam logic [3:0] ALU_SRA  = 4'h7;
  localparam logic [3:0] ALU_SLT  = 4'h8;
  localparam logic [3:0] ALU_SLTU = 4'h9;
  localparam logic [3:0] ALU_MUL  = 4'hA;
  localparam logic [3:0] ALU_DIV  = 4'hB;
  localparam logic [3:0] ALU_MOD  = 4'hC;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2,
    MD_DONE = 2'd3
  } md_state_e;

  function automatic logic is_md_op(
    input logic [3:0] op
  );
    return (op == ALU_MUL) ||
           (op == ALU_DIV) ||
           (op == ALU_MOD);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One shift-add multiply or restoring-divide iteration.
// Purely combinational; registers live in muldiv_seq.
module muldiv_step #(
  parameter int W = 32
) (
  input  logic         div,
  input  logic [W-1:0] acc,
  input  logic [W-1:0] qr,
  input  logic [W-1:0] opa,
  input  logic [W-1:0] opb,
  output logic [W-1:0] acc_n,
  output logic [W-1:0] qr_n,
  output logic [W-1:0] opa_n
);

  logic [W:0]   rw;
  logic [W-1:0] diff;
  logic         ge;

  always_comb begin
    // shifted remainder needs W+1 bits; a kept difference always fits W
    rw    = {acc, qr[W-1]};
    ge    = rw >= {1'b0, opb};
    diff  = rw[W-1:0] - opb;
    acc_n = acc;
    qr_n  = qr;
    opa_n = opa;
    if (div) begin
      acc_n = ge ? diff : rw[W-1:0];
      qr_n  = {qr[W-2:0], ge};
    end else begin
      acc_n = acc + (qr[0] ? opa : '0);
      qr_n  = qr >> 1;
      opa_n = opa << 1;
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MUL/DIV/MOD sequencer for the execute stage.
// FSM, iteration counter and all state registers live here.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         flush,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] y
);

  localparam int CW = $clog2(W);

  md_state_e    state;
  logic [CW-1:0] cnt;
  logic [W-1:0] acc;
  logic [W-1:0] qr;
  logic [W-1:0] opa;
  logic [W-1:0] opb;
  logic         mod_op;
  logic [W-1:0] acc_n;
  logic [W-1:0] qr_n;
  logic [W-1:0] opa_n;

  muldiv_step #(.W(W)) u_step (
    .div   (state == MD_DIV),
    .acc   (acc),
    .qr    (qr),
    .opa   (opa),
    .opb   (opb),
    .acc_n (acc_n),
    .qr_n  (qr_n),
    .opa_n (opa_n)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= MD_IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      y      <= '0;
      acc    <= '0;
      qr     <= '0;
      opa    <= '0;
      opb    <= '0;
      mod_op <= 1'b0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= MD_IDLE;
        busy  <= 1'b0;
      end else begin
        unique case (state)
          MD_IDLE: begin
            if (start && is_md_op(op)) begin
              cnt    <= '0;
              acc    <= '0;
              opa    <= a;
              opb    <= b;
              mod_op <= (op == ALU_MOD);
              busy   <= 1'b1;
              if (op == ALU_MUL) begin
                qr    <= b;
                state <= MD_MUL;
              end else if (b == '0) begin
                // zero divisor resolves at accept
                state <= MD_DONE;
                done  <= 1'b1;
                y     <= (op == ALU_MOD) ? a : '1;
              end else begin
                qr    <= a;
                state <= MD_DIV;
              end
            end
          end
          MD_MUL, MD_DIV: begin
            acc <= acc_n;
            qr  <= qr_n;
            opa <= opa_n;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(W - 1)) begin
              state <= MD_DONE;
              done  <= 1'b1;
              if (state == MD_MUL || mod_op)
                y <= acc_n;
              else
                y <= qr_n;
            end
          end
          MD_DONE: begin
            state <= MD_IDLE;
            busy  <= 1'b0;
          end
          default: state <= MD_IDLE;
        endcase
      end
    end
  end

endmodule
